laser_search_ctrl: RTL
======================

# laser_search_ctrl

Search sequencer for the two-circle laser coverage engine. It walks candidate circle centres over the 16x16 grid and issues one candidate at a time to the shared coverage evaluator over a req/ack handshake. It tracks the best-scoring centre and alternates between circle 1 and circle 2 across one full-grid pass and ITERS windowed refinement passes. It sits between the point-buffer/evaluator datapath and the top-level result outputs.

## Interface
- WIN, 3: refinement half-window; candidates span c-WIN..c+WIN per axis, clipped to 0..15
- ITERS, 3: number of refinement passes after the full-grid pass
- CNT_W, 6: width of coverage count
- CLK  in  1  clock, rising edge
- RST  in  1  reset, asynchronous, active-high
- start  in  1  begin search; sampled only in IDLE
- eval_req  out  1  candidate valid to evaluator
- eval_sel  out  1  circle being moved (0 = circle 1, 1 = circle 2)
- eval_cx, eval_cy  out  4 each  candidate centre
- eval_ack  in  1  evaluator done; eval_cnt valid this cycle
- eval_cnt  in  CNT_W  points covered by the union of the candidate and the fixed other circle
- C1X, C1Y, C2X, C2Y  out  4 each  committed circle centres
- busy  out  1  high from the cycle after start until DONE
- DONE  out  1  one-cycle completion pulse

## Operation
- States:
  - IDLE: on start, clear C1/C2 to (0,0), pass=0, sel=0, load scan window, go to ISSUE.
  - ISSUE: eval_req=1 with stable sel/cx/cy. On eval_ack, latch eval_cnt and go to UPDATE.
  - UPDATE: compare and advance the candidate. If more candidates remain in the window, go to ISSUE. Otherwise commit the best centre to C(sel), then go to NEXT.
  - NEXT:
    - sel 0 → 1: load the window around C2.
    - sel 1 → 0: pass+1 and load the window around C1.
    - If pass would exceed ITERS, go to FIN.
  - FIN: DONE=1, then IDLE.
- Window:
  - pass 0 is the full grid, lo=0 and hi=15.
  - Otherwise lo=(c<WIN)?0:c-WIN and hi=(c>15-WIN)?15:c+WIN per axis, with c the committed centre of the moving circle at window load.
- Scan order is raster: x fastest from lo_x to hi_x, then y+1. The last candidate is (hi_x, hi_y).
- Best tracking:
  - best_cnt is cleared to 0 at window load.
  - The candidate replaces best when eval_cnt >= best_cnt, so on ties the last candidate wins.
  - best_cnt width is CNT_W.
- C1/C2 change only at commit, never mid-scan. The evaluator reads the fixed circle from C1/C2.
- Total requests: 2*256 plus the sum over refinement windows of window sizes (at most 2*ITERS*(2WIN+1)^2).
- start while busy is ignored. eval_ack while eval_req=0 is ignored.

## Timing
- Reset values: eval_req=0, eval_sel=0, eval_cx/cy=0, C1X..C2Y=0, busy=0, DONE=0, state IDLE.
- RST mid-search aborts immediately: eval_req drops asynchronously and no further request is issued until a new start.
- start high in IDLE at cycle T gives eval_req=1 with (0,0), sel=0 at T+1, and busy=1 from T+1.
- ack at cycle A: eval_req=0 at A+1 (UPDATE), next eval_req=1 at A+2. Minimum 2 cycles per candidate with zero-wait ack.
- ack in the same cycle req rises is legal.
- eval_sel/cx/cy hold while eval_req=1 and no ack.
- Commit in the UPDATE cycle is visible on C outputs the next cycle. NEXT takes 1 cycle.
- DONE pulses 1 cycle after the final NEXT. busy falls with DONE (busy=0 in the DONE cycle). C outputs hold until the next start.

## Test plan
- Reset: assert RST mid-scan → all outputs 0 within the same cycle, no eval_req until start, next start scans from (0,0) sel=0.
- Constant evaluator, eval_cnt=0 with zero-wait ack → ties resolve to (15,15) for both circles. Refinement windows are x,y 12..15 (16 candidates). Exactly 608 requests, C1=C2=(15,15), DONE once.
- Peaked evaluator:
  - sel0 returns 40-|cx-7|-|cy-3|; sel1 returns 40-|cx-12|-|cy-10|.
  - → C1=(7,3), C2=(12,10). Refinement windows are 4..10×0..6 and 9..15×7..13.
- Low-edge clipping: sel0 peak at (1,2) → first refinement window x 0..4, y 0..5, 30 requests in raster order starting (0,0) and ending (4,5).
- Handshake stall: random 0–5 cycle ack delay → cx/cy/sel stable while req is high, results identical to the zero-wait run, min 2-cycle spacing respected.
- Spurious inputs: start pulsed while busy and eval_ack pulsed with req low → no effect on request count or results.

Source files
------------

// File: rtl/laser_search_ctrl_if.sv
// Candidate handshake between the search sequencer and the coverage evaluator.
//   eval_req  : candidate valid (sequencer -> evaluator)
//   eval_sel  : circle being moved, 0 = circle 1, 1 = circle 2
//   eval_cx/cy: candidate centre on the 16x16 grid
//   eval_ack  : evaluator done, eval_cnt valid this cycle (evaluator -> sequencer)
//   eval_cnt  : points covered by the candidate united with the fixed circle
interface laser_search_ctrl_if #(
   parameter int unsigned CNT_W = 6
);
   logic             eval_req;
   logic             eval_sel;
   logic [3:0]       eval_cx;
   logic [3:0]       eval_cy;
   logic             eval_ack;
   logic [CNT_W-1:0] eval_cnt;

   modport master (
      output eval_req, eval_sel, eval_cx, eval_cy,
      input  eval_ack, eval_cnt
   );

   modport slave (
      input  eval_req, eval_sel, eval_cx, eval_cy,
      output eval_ack, eval_cnt
   );
endinterface

// File: rtl/laser_search_ctrl.sv
// Search sequencer for the two-circle laser coverage engine. Runs one full-grid
// pass and ITERS windowed refinement passes, alternating circle 1 and circle 2,
// issuing one candidate centre at a time and committing the best-scoring one.
// Ports:
//   CLK, RST       : clock (rising edge), asynchronous active-high reset
//   start          : begin a search, sampled only while idle
//   ev             : evaluator handshake (master side)
//   C1X..C2Y       : committed circle centres
//   busy           : search in progress
//   DONE           : one-cycle completion pulse
module laser_search_ctrl #(
   parameter int unsigned WIN   = 3,
   parameter int unsigned ITERS = 3,
   parameter int unsigned CNT_W = 6
) (
   input  logic                CLK,
   input  logic                RST,
   input  logic                start,
   laser_search_ctrl_if.master ev,
   output logic [3:0]          C1X,
   output logic [3:0]          C1Y,
   output logic [3:0]          C2X,
   output logic [3:0]          C2Y,
   output logic                busy,
   output logic                DONE
);

   localparam int unsigned PASS_W = (ITERS < 1) ? 1 : $clog2(ITERS + 1);

   typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_UPDATE, S_NEXT, S_FIN} state_t;

   state_t             state;
   logic [PASS_W-1:0]  pass;
   logic [3:0]         lo_x, hi_x, lo_y, hi_y;
   logic [3:0]         best_x, best_y;
   logic [CNT_W-1:0]   best_cnt;
   logic [CNT_W-1:0]   cnt_q;

   logic [3:0]         ctr_x_c, ctr_y_c;
   logic [3:0]         nlo_x_c, nhi_x_c, nlo_y_c, nhi_y_c;
   logic               full_c, take_c, last_c;

   // Window edges clipped to the grid; guards keep the 4-bit arithmetic from wrapping.
   function automatic logic [3:0] win_lo(input logic [3:0] c);
      return (c < 4'(WIN)) ? 4'd0 : c - 4'(WIN);
   endfunction

   function automatic logic [3:0] win_hi(input logic [3:0] c);
      return (c > 4'(15 - WIN)) ? 4'd15 : c + 4'(WIN);
   endfunction

   // Next window, used in NEXT: the circle about to move is the other one.
   always_comb begin
      ctr_x_c = ev.eval_sel ? C1X : C2X;
      ctr_y_c = ev.eval_sel ? C1Y : C2Y;
      full_c  = (pass == '0) && !ev.eval_sel;
      nlo_x_c = full_c ? 4'd0  : win_lo(ctr_x_c);
      nhi_x_c = full_c ? 4'd15 : win_hi(ctr_x_c);
      nlo_y_c = full_c ? 4'd0  : win_lo(ctr_y_c);
      nhi_y_c = full_c ? 4'd15 : win_hi(ctr_y_c);
      take_c  = (cnt_q >= best_cnt);
      last_c  = (ev.eval_cx == hi_x) && (ev.eval_cy == hi_y);
   end

   // Sequencer state machine with registered outputs.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state       <= S_IDLE;
         pass        <= '0;
         lo_x        <= 4'd0;
         hi_x        <= 4'd0;
         lo_y        <= 4'd0;
         hi_y        <= 4'd0;
         best_x      <= 4'd0;
         best_y      <= 4'd0;
         best_cnt    <= '0;
         cnt_q       <= '0;
         ev.eval_req <= 1'b0;
         ev.eval_sel <= 1'b0;
         ev.eval_cx  <= 4'd0;
         ev.eval_cy  <= 4'd0;
         C1X         <= 4'd0;
         C1Y         <= 4'd0;
         C2X         <= 4'd0;
         C2Y         <= 4'd0;
         busy        <= 1'b0;
         DONE        <= 1'b0;
      end else begin
         DONE <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  C1X         <= 4'd0;
                  C1Y         <= 4'd0;
                  C2X         <= 4'd0;
                  C2Y         <= 4'd0;
                  pass        <= '0;
                  lo_x        <= 4'd0;
                  hi_x        <= 4'd15;
                  lo_y        <= 4'd0;
                  hi_y        <= 4'd15;
                  best_cnt    <= '0;
                  ev.eval_sel <= 1'b0;
                  ev.eval_cx  <= 4'd0;
                  ev.eval_cy  <= 4'd0;
                  ev.eval_req <= 1'b1;
                  busy        <= 1'b1;
                  state       <= S_ISSUE;
               end
            end

            S_ISSUE: begin
               if (ev.eval_ack && ev.eval_req) begin
                  cnt_q       <= ev.eval_cnt;
                  ev.eval_req <= 1'b0;
                  state       <= S_UPDATE;
               end
            end

            S_UPDATE: begin
               // >= so that on ties the later candidate wins
               if (take_c) begin
                  best_cnt <= cnt_q;
                  best_x   <= ev.eval_cx;
                  best_y   <= ev.eval_cy;
               end
               if (!last_c) begin
                  if (ev.eval_cx == hi_x) begin
                     ev.eval_cx <= lo_x;
                     ev.eval_cy <= ev.eval_cy + 4'd1;
                  end else begin
                     ev.eval_cx <= ev.eval_cx + 4'd1;
                  end
                  ev.eval_req <= 1'b1;
                  state       <= S_ISSUE;
               end else begin
                  // Commit includes the final candidate's own result
                  if (ev.eval_sel) begin
                     C2X <= take_c ? ev.eval_cx : best_x;
                     C2Y <= take_c ? ev.eval_cy : best_y;
                  end else begin
                     C1X <= take_c ? ev.eval_cx : best_x;
                     C1Y <= take_c ? ev.eval_cy : best_y;
                  end
                  state <= S_NEXT;
               end
            end

            S_NEXT: begin
               if (ev.eval_sel && (pass >= PASS_W'(ITERS))) begin
                  busy  <= 1'b0;
                  DONE  <= 1'b1;
                  state <= S_FIN;
               end else begin
                  if (ev.eval_sel) pass <= pass + PASS_W'(1);
                  ev.eval_sel <= !ev.eval_sel;
                  lo_x        <= nlo_x_c;
                  hi_x        <= nhi_x_c;
                  lo_y        <= nlo_y_c;
                  hi_y        <= nhi_y_c;
                  ev.eval_cx  <= nlo_x_c;
                  ev.eval_cy  <= nlo_y_c;
                  best_cnt    <= '0;
                  ev.eval_req <= 1'b1;
                  state       <= S_ISSUE;
               end
            end

            S_FIN: begin
               state <= S_IDLE;
            end

            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
